// File: rtl/alu_issue_ctrl.sv
// Issue stage: decodes a MIPS word into ALU controls/operands (D register) and
// captures the ALU result and flags (R register). Define ALU_TRAP_EN for signed overflow traps.
module alu_issue_ctrl #(
    parameter int DW         = 32,
    parameter int ILL_STICKY = 1
) (
    input  logic          iClk,
    input  logic          iRst_n,
    input  logic          iValid,
    output logic          oReady,
    input  logic [31:0]   iInstr,
    input  logic [DW-1:0] iRsData,
    input  logic [DW-1:0] iRtData,
    output logic [5:0]    oALUFun,
    output logic          oSign,
    output logic [DW-1:0] oA,
    output logic [DW-1:0] oB,
    input  logic [DW-1:0] iS,
    input  logic          iZ,
    input  logic          iV,
    input  logic          iN,
    output logic          oResValid,
    input  logic          iResReady,
    output logic [DW-1:0] oResult,
    output logic          oBranch,
    output logic          oIllegal,
    output logic          oOvf,
    input  logic          iExcClr
);

    localparam logic [5:0] FunAdd  = 6'b000000;
    localparam logic [5:0] FunSub  = 6'b000001;
    localparam logic [5:0] FunAnd  = 6'b011000;
    localparam logic [5:0] FunOr   = 6'b011110;
    localparam logic [5:0] FunXor  = 6'b010110;
    localparam logic [5:0] FunNor  = 6'b010001;
    localparam logic [5:0] FunSlt  = 6'b110101;
    localparam logic [5:0] FunSll  = 6'b100000;
    localparam logic [5:0] FunSrl  = 6'b100001;
    localparam logic [5:0] FunSra  = 6'b100011;
    localparam logic [5:0] FunPass = 6'b011010;
    localparam logic [5:0] FunEq   = 6'b110011;
    localparam logic [5:0] FunNe   = 6'b110001;
    localparam logic [5:0] FunLez  = 6'b111101;
    localparam logic [5:0] FunGtz  = 6'b111111;
    localparam logic [5:0] FunGez  = 6'b111001;

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    shamt;
    logic [15:0]   imm;
    logic [DW-1:0] immSext;
    logic [DW-1:0] immZext;

    logic [5:0]    decFun;
    logic          decSign;
    logic [DW-1:0] decA;
    logic [DW-1:0] decB;
    logic          decBranch;
    logic          decIllegal;
    logic          decTrap;

    logic          dValid;
    logic [5:0]    dFun;
    logic          dSign;
    logic [DW-1:0] dA;
    logic [DW-1:0] dB;
    logic          dBranch;
    logic          dIllegal;
    logic          dTrap;

    logic          resValid;
    logic [DW-1:0] result;
    logic          branch;
    logic          illegal;
    logic          rFree;
    logic          dLoad;
    logic          rCapture;
    logic          trapHit;
    logic          unusedSigs;

    assign opcode  = iInstr[31:26];
    assign funct   = iInstr[5:0];
    assign shamt   = iInstr[10:6];
    assign imm     = iInstr[15:0];
    assign immSext = {{(DW-16){imm[15]}}, imm};
    assign immZext = {{(DW-16){1'b0}}, imm};

    // Instruction decode; anything unrecognised becomes a pass-A of zero flagged illegal.
    always_comb begin
        decFun     = FunPass;
        decSign    = 1'b0;
        decA       = iRsData;
        decB       = iRtData;
        decBranch  = 1'b0;
        decIllegal = 1'b0;
        decTrap    = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: begin decFun = FunAdd; decSign = 1'b1; decTrap = 1'b1; end
                    6'h21: decFun = FunAdd;
                    6'h22: begin decFun = FunSub; decSign = 1'b1; decTrap = 1'b1; end
                    6'h23: decFun = FunSub;
                    6'h24: decFun = FunAnd;
                    6'h25: decFun = FunOr;
                    6'h26: decFun = FunXor;
                    6'h27: decFun = FunNor;
                    6'h2A: begin decFun = FunSlt; decSign = 1'b1; end
                    6'h2B: decFun = FunSlt;
                    6'h00: begin decFun = FunSll; decA = {{(DW-5){1'b0}}, shamt}; end
                    6'h02: begin decFun = FunSrl; decA = {{(DW-5){1'b0}}, shamt}; end
                    6'h03: begin decFun = FunSra; decA = {{(DW-5){1'b0}}, shamt}; end
                    default: decIllegal = 1'b1;
                endcase
            end
            6'h01: begin
                decB      = '0;
                decSign   = 1'b1;
                decBranch = 1'b1;
                if (iInstr[20:16] == 5'd1) begin
                    decFun = FunGez;
                end else if (iInstr[20:16] == 5'd0) begin
                    decFun = FunSlt;
                end else begin
                    decSign    = 1'b0;
                    decBranch  = 1'b0;
                    decIllegal = 1'b1;
                end
            end
            6'h04: begin decFun = FunEq; decSign = 1'b1; decBranch = 1'b1; end
            6'h05: begin decFun = FunNe; decSign = 1'b1; decBranch = 1'b1; end
            6'h06: begin decFun = FunLez; decSign = 1'b1; decBranch = 1'b1; decB = '0; end
            6'h07: begin decFun = FunGtz; decSign = 1'b1; decBranch = 1'b1; decB = '0; end
            6'h08: begin decFun = FunAdd; decSign = 1'b1; decB = immSext; decTrap = 1'b1; end
            6'h09: begin decFun = FunAdd; decB = immSext; end
            6'h0A: begin decFun = FunSlt; decSign = 1'b1; decB = immSext; end
            6'h0B: begin decFun = FunSlt; decB = immSext; end
            6'h0C: begin decFun = FunAnd; decB = immZext; end
            6'h0D: begin decFun = FunOr;  decB = immZext; end
            6'h0E: begin decFun = FunXor; decB = immZext; end
            6'h0F: begin decFun = FunPass; decA = {imm, {(DW-16){1'b0}}}; decB = '0; end
            default: decIllegal = 1'b1;
        endcase
        if (decIllegal) begin
            decA = '0;
            decB = '0;
        end
    end

    assign rFree    = !resValid || iResReady;
    assign oReady   = !dValid || rFree;
    assign dLoad    = iValid && oReady;
    assign rCapture = dValid && rFree;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            dValid   <= 1'b0;
            dFun     <= '0;
            dSign    <= 1'b0;
            dA       <= '0;
            dB       <= '0;
            dBranch  <= 1'b0;
            dIllegal <= 1'b0;
            dTrap    <= 1'b0;
        end else if (dLoad) begin
            dValid   <= 1'b1;
            dFun     <= decFun;
            dSign    <= decSign;
            dA       <= decA;
            dB       <= decB;
            dBranch  <= decBranch;
            dIllegal <= decIllegal;
            dTrap    <= decTrap;
        end else if (rCapture) begin
            dValid <= 1'b0;
        end
    end

    assign oALUFun = dFun;
    assign oSign   = dSign;
    assign oA      = dA;
    assign oB      = dB;

    // Result register holds steady until the consumer takes it.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            resValid <= 1'b0;
            result   <= '0;
            branch   <= 1'b0;
        end else if (rCapture) begin
            resValid <= 1'b1;
            result   <= trapHit ? '0 : iS;
            branch   <= dBranch && iS[0] && !trapHit;
        end else if (iResReady) begin
            resValid <= 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            illegal <= 1'b0;
        end else if (iExcClr) begin
            illegal <= 1'b0;
        end else if (rCapture && dIllegal) begin
            illegal <= 1'b1;
        end else if (ILL_STICKY == 0) begin
            illegal <= 1'b0;
        end
    end

`ifdef ALU_TRAP_EN
    logic ovf;

    assign trapHit = dTrap && iV;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ovf <= 1'b0;
        end else if (iExcClr) begin
            ovf <= 1'b0;
        end else if (rCapture && trapHit) begin
            ovf <= 1'b1;
        end
    end

    assign oOvf       = ovf;
    assign unusedSigs = ^{iZ, iN};
`else
    assign trapHit    = 1'b0;
    assign oOvf       = 1'b0;
    assign unusedSigs = ^{iZ, iN, iV, dTrap};
`endif

    assign oResValid = resValid;
    assign oResult   = result;
    assign oBranch   = branch;
    assign oIllegal  = illegal;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue stage between register-file read and the combinational ALU.
- Decodes a MIPS instruction word into ALU function code, sign mode and operands, and holds them in a valid/ready pipeline register that drives the ALU.
- Captures the ALU result and flags (S/Z/V/N) into a result register, then raises branch-taken, illegal-instruction and overflow indications.
- Sits after register read and before writeback/PC select.

Parameters:
- DW, 32, datapath width for operands and result; only 32 is supported.
- ILL_STICKY, 1, when 1 the illegal-instruction flag holds until iExcClr; when 0 it is a one-cycle pulse.

Ports:
- iClk  input  1  clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iValid  input  1  upstream instruction valid.
- oReady  output  1  stage can accept an instruction.
- iInstr  input  32  instruction word.
- iRsData  input  32  rs register value.
- iRtData  input  32  rt register value.
- oALUFun  output  6  function code to the ALU.
- oSign  output  1  signed-mode select to the ALU.
- oA  output  32  ALU operand A.
- oB  output  32  ALU operand B.
- iS  input  32  ALU result.
- iZ  input  1  ALU zero flag.
- iV  input  1  ALU overflow flag.
- iN  input  1  ALU negative flag.
- oResValid  output  1  result register holds a valid result.
- iResReady  input  1  downstream consumes the result.
- oResult  output  32  registered ALU result.
- oBranch  output  1  branch condition true; qualified by oResValid.
- oIllegal  output  1  unsupported opcode/funct decoded.
- oOvf  output  1  overflow trap flag (sticky).
- iExcClr  input  1  clears oOvf and a sticky oIllegal.

Behaviour:
- Reset (iRst_n low, asynchronous): all pipeline valids 0; oALUFun=000000; oSign=0; oA=oB=0; oResult=0; oBranch=oIllegal=oOvf=0. oReady=1 after reset release.
- Two register stages:
  - D: decode register that drives the ALU.
  - R: result register.
- Stage D:
  - Loads when iValid && oReady.
  - oReady = !Dvalid || (Rfree), where Rfree = !oResValid || iResReady.
- Stage R:
  - Captures iS/iZ/iN/iV when Dvalid && Rfree.
  - One-cycle issue-to-result latency; full throughput of one instruction per cycle.
- oResValid holds with a stable oResult until iResReady.
- Simultaneous accept and drain in the same cycle is legal and loses no bubble.
- Decode table (ALUFun / Sign / A / B):
  - ADD: 000000/1/rs/rt. ADDU: 000000/0/rs/rt.
  - SUB: 000001/1/rs/rt. SUBU: 000001/0/rs/rt.
  - AND 011000, OR 011110, XOR 010110, NOR 010001: Sign=0, A=rs, B=rt.
  - SLT: 110101/1. SLTU: 110101/0.
  - SLL 100000, SRL 100001, SRA 100011: A={27'b0,shamt}, B=rt; the ALU shifts B by A[4:0].
  - ADDI: 000000/1, B=sign-extended imm. ADDIU: 000000/0, B=sign-extended imm.
  - SLTI: 110101/1, B=sign-extended imm. SLTIU: 110101/0, B=sign-extended imm.
  - ANDI, ORI, XORI: B=zero-extended imm.
  - LUI: 011010 (pass A), A={imm,16'b0}.
  - BEQ 110011, BNE 110001: A=rs, B=rt, Sign=1.
  - BLEZ 111101, BGTZ 111111, BGEZ (REGIMM rt=1) 111001, BLTZ (REGIMM rt=0) 110101: B=0, Sign=1.
- oBranch = registered iS[0] for branch opcodes, else 0.
- Any other opcode/funct:
  - Decodes as ALUFun=011010, A=0 (NOP result).
  - Sets oIllegal when the instruction reaches R.
  - Still flows through the pipeline.
- iExcClr has priority over a same-cycle set of oIllegal/oOvf.
- Reset mid-flight discards both stages; no partial result is emitted.

Optional Feature:
- Macro: ALU_TRAP_EN.
- When defined:
  - Signed ADD/SUB/ADDI capturing iV=1 sets oOvf (sticky until iExcClr).
  - That result is delivered with oResult forced to 0 and oBranch=0.
  - Unsigned variants never trap.
- When undefined:
  - oOvf is tied to 0.
  - iV is ignored.
  - Results pass unmodified.

Test Plan:
- ADD rs=5, rt=7, iS returned 12 -> oALUFun=000000, oSign=1; one cycle later oResValid=1, oResult=12.
- ORI rs=0x00F0, imm=0x8001 -> oB=0x00008001 (zero-extended), oALUFun=011110; ADDI imm=0xFFFF -> oB=0xFFFFFFFF.
- BLTZ rs=0xFFFFFFFE, ALU returns iS=1 -> oALUFun=110101, oB=0, oBranch=1 with oResValid.
- Back-to-back 3 instructions with iResReady low for 2 cycles -> oReady drops after D and R fill, oResult stable; no loss or duplication after release.
- Funct 0x3F under opcode 0 -> oIllegal=1 at R; iExcClr pulse -> 0 (ILL_STICKY=1).
- ALU_TRAP_EN: ADD 0x7FFFFFFF+1 with iV=1 -> oOvf=1, oResult=0; ADDU same operands -> oOvf stays 0. Assert iRst_n low mid-stream -> all outputs 0 immediately.
